// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES-128 round sequencer
// Contents: aes_state_t sequencer state, AES_NUM_ROUNDS, AES_ROUND_W, is_wait_state().

package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_ROUND_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_ARK0,
    ST_W_SB,
    ST_W_SR,
    ST_W_MC,
    ST_W_ARK,
    ST_DONE,
    ST_ERROR
  } aes_state_t;

  // True in the states that are waiting on a stage's finished handshake.
  function automatic logic is_wait_state(aes_state_t s);
    return (s == ST_W_ARK0) || (s == ST_W_SB) || (s == ST_W_SR) ||
           (s == ST_W_MC) || (s == ST_W_ARK);
  endfunction

endpackage

// File: rtl/aes_watchdog.sv
// rtl/aes_watchdog.sv - 8-bit stage wait counter with timeout flag
// Ports: clk, n_rst (async, active-low); clear restarts the count, enable
//        advances it; timeout is high in the last permitted waiting cycle.

module aes_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // count is 0 in the first waiting cycle, so TIMEOUT_CYCLES waiting cycles
  // have elapsed when the edge closing count == TIMEOUT_CYCLES-1 is reached.
  assign timeout = enable && (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - AES-128 round sequencer for SubBytes/ShiftRows/MixColumns/AddRoundKey
// Optional stage watchdog: define AES_ROUND_CTRL_WATCHDOG_EN.
// Ports: clk, n_rst (async, active-low); start (sampled in IDLE/ERROR);
//        busy, done (1-cycle pulse), error, round_num;
//        sbytes/srows/mcols/ark _enable out (1-cycle start pulses), _finished in.

module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS     = AES_NUM_ROUNDS,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [AES_ROUND_W-1:0] round_num,
  output logic                   sbytes_enable,
  output logic                   srows_enable,
  output logic                   mcols_enable,
  output logic                   ark_enable,
  input  logic                   sbytes_finished,
  input  logic                   srows_finished,
  input  logic                   mcols_finished,
  input  logic                   ark_finished
);

  localparam logic [AES_ROUND_W-1:0] LAST_ROUND = AES_ROUND_W'(NUM_ROUNDS);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > (1 << AES_ROUND_W) - 1) begin : g_bad_num_rounds
    $error("aes_round_ctrl: NUM_ROUNDS does not fit round_num");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("aes_round_ctrl: TIMEOUT_CYCLES does not fit the 8-bit wait counter");
  end

  aes_state_t state;
  logic       stage_fin;
  logic       timeout;

  // Only the finished of the stage currently being waited on is honoured;
  // strays from other stages or outside W_ states fall through to 0.
  always_comb begin
    stage_fin = 1'b0;
    case (state)
      ST_W_ARK0, ST_W_ARK: stage_fin = ark_finished;
      ST_W_SB:             stage_fin = sbytes_finished;
      ST_W_SR:             stage_fin = srows_finished;
      ST_W_MC:             stage_fin = mcols_finished;
      default:             stage_fin = 1'b0;
    endcase
  end

`ifdef AES_ROUND_CTRL_WATCHDOG_EN
  logic in_wait;
  assign in_wait = is_wait_state(state);

  // Cleared whenever not waiting or when the wait ends, so the count always
  // starts from 0 on entry to a W_ state.
  aes_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (!in_wait || stage_fin),
    .enable (in_wait && !stage_fin),
    .timeout(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= ST_IDLE;
      round_num     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      sbytes_enable <= 1'b0;
      srows_enable  <= 1'b0;
      mcols_enable  <= 1'b0;
      ark_enable    <= 1'b0;
    end else begin
      // Enables and done are single-cycle: set only on the entering edge.
      sbytes_enable <= 1'b0;
      srows_enable  <= 1'b0;
      mcols_enable  <= 1'b0;
      ark_enable    <= 1'b0;
      done          <= 1'b0;
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            state      <= ST_W_ARK0;
            round_num  <= '0;
            busy       <= 1'b1;
            error      <= 1'b0;
            ark_enable <= 1'b1;
          end
        end
        ST_W_ARK0: begin
          if (stage_fin) begin
            state         <= ST_W_SB;
            round_num     <= AES_ROUND_W'(1);
            sbytes_enable <= 1'b1;
          end
        end
        ST_W_SB: begin
          if (stage_fin) begin
            state        <= ST_W_SR;
            srows_enable <= 1'b1;
          end
        end
        ST_W_SR: begin
          if (stage_fin) begin
            // The final round has no MixColumns.
            if (round_num < LAST_ROUND) begin
              state        <= ST_W_MC;
              mcols_enable <= 1'b1;
            end else begin
              state      <= ST_W_ARK;
              ark_enable <= 1'b1;
            end
          end
        end
        ST_W_MC: begin
          if (stage_fin) begin
            state      <= ST_W_ARK;
            ark_enable <= 1'b1;
          end
        end
        ST_W_ARK: begin
          if (stage_fin) begin
            if (round_num == LAST_ROUND) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state         <= ST_W_SB;
              round_num     <= round_num + AES_ROUND_W'(1);
              sbytes_enable <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          round_num <= '0;
          busy      <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
      // timeout is only raised while waiting without a finished, so no
      // transition or enable was scheduled above in that cycle.
      if (timeout) begin
        state <= ST_ERROR;
        busy  <= 1'b0;
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - self-checking bench for aes_round_ctrl

module tb_aes_round_ctrl;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [3:0] round_num;
  logic       sbytes_enable, srows_enable, mcols_enable, ark_enable;
  logic       sbytes_finished = 1'b0, srows_finished = 1'b0;
  logic       mcols_finished = 1'b0, ark_finished = 1'b0;

  aes_round_ctrl dut (
    .clk(clk), .n_rst(n_rst), .start(start), .busy(busy), .done(done),
    .error(error), .round_num(round_num),
    .sbytes_enable(sbytes_enable), .srows_enable(srows_enable),
    .mcols_enable(mcols_enable), .ark_enable(ark_enable),
    .sbytes_finished(sbytes_finished), .srows_finished(srows_finished),
    .mcols_finished(mcols_finished), .ark_finished(ark_finished)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Stage codes: 0 SB, 1 SR, 2 MC, 3 ARK.
  int lat_mode = 1;          // <0: random 0..5, else fixed latency
  bit stray_en = 1'b0;
  logic [3:0] no_resp = 4'b0;
  logic [3:0] force_mask = 4'b0;
  int force_req = 0;

  int lat_q[$];
  int enq_stage[$], enq_cyc[$], enq_rnd[$];
  int done_q[$], done_rnd[$];
  int multi_en = 0;
  int exp_stage[$], exp_rnd[$];

  // Stage responder: answers each enable after a chosen latency.
  always @(negedge clk) begin : responder
    logic [3:0] en_v, fin_v;
    int pend[4];
    logic [3:0] pact;
    int force_seen;
    int lat_v;
    en_v  = {ark_enable, mcols_enable, srows_enable, sbytes_enable};
    fin_v = 4'b0;
    if (!n_rst) begin
      pact = 4'b0;
    end else begin
      for (int s = 0; s < 4; s++) begin
        if (pact[s]) begin
          pend[s]--;
          if (pend[s] == 0) begin
            fin_v[s] = 1'b1;
            pact[s]  = 1'b0;
          end
        end
      end
      for (int s = 0; s < 4; s++) begin
        if (en_v[s] && !no_resp[s]) begin
          lat_v = (lat_mode < 0) ? int'($urandom_range(0, 5)) : lat_mode;
          lat_q.push_back(lat_v);
          if (lat_v == 0) fin_v[s] = 1'b1;
          else begin
            pend[s] = lat_v;
            pact[s] = 1'b1;
          end
        end
      end
      if (stray_en)
        for (int s = 0; s < 4; s++)
          if (!pact[s] && !en_v[s] && $urandom_range(0, 3) == 0) fin_v[s] = 1'b1;
    end
    if (force_seen != force_req) begin
      fin_v = fin_v | force_mask;
      force_seen = force_req;
    end
    {ark_finished, mcols_finished, srows_finished, sbytes_finished} = fin_v;
  end

  always @(negedge clk) begin : monitor
    logic [3:0] en_v;
    en_v = {ark_enable, mcols_enable, srows_enable, sbytes_enable};
    if ($countones(en_v) > 1) multi_en++;
    for (int s = 0; s < 4; s++)
      if (en_v[s]) begin
        enq_stage.push_back(s);
        enq_cyc.push_back(cyc);
        enq_rnd.push_back(int'(round_num));
      end
    if (done) begin
      done_q.push_back(cyc);
      done_rnd.push_back(int'(round_num));
    end
  end

  // Reference: expected stage order and round per enable for one block.
  task automatic model_block();
    exp_stage.push_back(3); exp_rnd.push_back(0);
    for (int r = 1; r <= N; r++) begin
      exp_stage.push_back(0); exp_rnd.push_back(r);
      exp_stage.push_back(1); exp_rnd.push_back(r);
      if (r < N) begin exp_stage.push_back(2); exp_rnd.push_back(r); end
      exp_stage.push_back(3); exp_rnd.push_back(r);
    end
  endtask

  task automatic test_reset();
    logic [10:0] v;
    repeat (3) @(negedge clk);
    v = {busy, done, error, sbytes_enable, srows_enable, mcols_enable, ark_enable, round_num};
    n_cmp++;
    if (v !== 11'b0) begin n_bad++; $display("FAIL reset_held outputs=%b want 0", v); end
    n_rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      v = {busy, done, error, sbytes_enable, srows_enable, mcols_enable, ark_enable, round_num};
      n_cmp++;
      if (v !== 11'b0) begin n_bad++; $display("FAIL reset_idle cycle %0d outputs=%b want 0", k, v); end
    end
  endtask

  task automatic test_nominal();
    int b, d, eb, c0, mc;
    lat_mode = 1; stray_en = 1'b0; no_resp = 4'b0;
    b = enq_stage.size(); d = done_q.size(); eb = exp_stage.size();
    model_block();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; c0 = cyc; start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || ark_enable !== 1'b1 || round_num !== 4'd0) begin
      n_bad++; $display("FAIL nominal_first busy=%b ark_en=%b round=%0d want 1 1 0", busy, ark_enable, round_num);
    end
    for (int k = 0; k < 300 && done_q.size() == d; k++) @(posedge clk);
    n_cmp++;
    if (done_q.size() != d + 1) begin
      n_bad++; $display("FAIL nominal_done count=%0d want 1", done_q.size() - d);
    end else begin
      n_cmp++;
      if (done_q[d] - c0 != 80) begin n_bad++; $display("FAIL nominal_done_time got %0d want 80", done_q[d] - c0); end
      n_cmp++;
      if (done_rnd[d] != N) begin n_bad++; $display("FAIL nominal_done_round got %0d want %0d", done_rnd[d], N); end
      n_cmp++;
      if (enq_stage.size() - b != 40) begin n_bad++; $display("FAIL nominal_enable_count got %0d want 40", enq_stage.size() - b); end
      n_cmp++;
      if (enq_cyc[b] != c0) begin n_bad++; $display("FAIL nominal_first_enable_cycle got %0d want %0d", enq_cyc[b], c0); end
      mc = 0;
      for (int i = 0; i < 40 && b + i < enq_stage.size(); i++) begin
        if (enq_stage[b + i] == 2) mc++;
        n_cmp++;
        if (enq_stage[b + i] != exp_stage[eb + i] || enq_rnd[b + i] != exp_rnd[eb + i]) begin
          n_bad++; $display("FAIL nominal_seq[%0d] got stage %0d round %0d want stage %0d round %0d",
                            i, enq_stage[b + i], enq_rnd[b + i], exp_stage[eb + i], exp_rnd[eb + i]);
        end
      end
      n_cmp++;
      if (mc != 9) begin n_bad++; $display("FAIL nominal_mcols_count got %0d want 9", mc); end
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || round_num !== 4'd0) begin
      n_bad++; $display("FAIL nominal_after busy=%b done=%b round=%0d want 0 0 0", busy, done, round_num);
    end
  endtask

  task automatic test_random();
    int b, d, eb, lb, c0, t_exp;
    lat_mode = -1; stray_en = 1'b1; no_resp = 4'b0;
    for (int blk = 0; blk < 3; blk++) begin
      b = enq_stage.size(); d = done_q.size(); eb = exp_stage.size(); lb = lat_q.size();
      model_block();
      repeat ($urandom_range(1, 4)) @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1; c0 = cyc; start = 1'b0;
      for (int k = 0; k < 400 && done_q.size() == d; k++) @(posedge clk);
      repeat (3) @(posedge clk);
      n_cmp++;
      if (done_q.size() != d + 1 || enq_stage.size() - b != 40 || lat_q.size() - lb != 40) begin
        n_bad++; $display("FAIL random_counts blk %0d dones=%0d enables=%0d want 1 40", blk, done_q.size() - d, enq_stage.size() - b);
      end else begin
        n_cmp++;
        if (enq_cyc[b] != c0) begin n_bad++; $display("FAIL random_first_enable blk %0d got %0d want %0d", blk, enq_cyc[b], c0); end
        t_exp = enq_cyc[b];
        for (int i = 0; i < 40; i++) begin
          n_cmp++;
          if (enq_stage[b + i] != exp_stage[eb + i] || enq_rnd[b + i] != exp_rnd[eb + i] || enq_cyc[b + i] != t_exp) begin
            n_bad++; $display("FAIL random_seq blk %0d [%0d] got stage %0d round %0d cyc %0d want %0d %0d %0d", blk, i,
                              enq_stage[b + i], enq_rnd[b + i], enq_cyc[b + i], exp_stage[eb + i], exp_rnd[eb + i], t_exp);
          end
          t_exp = t_exp + 1 + lat_q[lb + i];
        end
        n_cmp++;
        if (done_q[d] != t_exp || done_rnd[d] != N) begin
          n_bad++; $display("FAIL random_done blk %0d got cyc %0d round %0d want %0d %0d", blk, done_q[d], done_rnd[d], t_exp, N);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int b, d, eb, d1;
    lat_mode = -1; stray_en = 1'b1; no_resp = 4'b0;
    b = enq_stage.size(); d = done_q.size(); eb = exp_stage.size();
    model_block(); model_block();
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      if (done_q.size() > d) break;
      @(negedge clk); start = ($urandom_range(0, 1) == 1);
    end
    #1; start = 1'b1;
    d1 = (done_q.size() > d) ? done_q[d] : -100;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 400 && done_q.size() < d + 2; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    n_cmp++;
    if (done_q.size() != d + 2 || enq_stage.size() - b != 80) begin
      n_bad++; $display("FAIL b2b_counts dones=%0d enables=%0d want 2 80", done_q.size() - d, enq_stage.size() - b);
    end else begin
      n_cmp++;
      if (enq_cyc[b + 40] != d1 + 2) begin n_bad++; $display("FAIL b2b_restart_cycle got %0d want %0d", enq_cyc[b + 40], d1 + 2); end
      n_cmp++;
      if (done_rnd[d] != N || done_rnd[d + 1] != N) begin n_bad++; $display("FAIL b2b_done_round got %0d %0d want %0d", done_rnd[d], done_rnd[d + 1], N); end
      for (int i = 0; i < 80; i++) begin
        n_cmp++;
        if (enq_stage[b + i] != exp_stage[eb + i] || enq_rnd[b + i] != exp_rnd[eb + i]) begin
          n_bad++; $display("FAIL b2b_seq[%0d] got stage %0d round %0d want %0d %0d", i, enq_stage[b + i], enq_rnd[b + i], exp_stage[eb + i], exp_rnd[eb + i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int b, d, nen;
    logic [10:0] v;
    bit found;
    lat_mode = 1; stray_en = 1'b0; no_resp = 4'b0;
    b = enq_stage.size(); d = done_q.size(); found = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (enq_stage.size() > b && enq_stage[$] == 2 && enq_rnd[$] == 5) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL reset_mid_reach_mc5 got none want round 5 mcols_enable"); end
    #1; n_rst = 1'b0; #1;
    v = {busy, done, error, sbytes_enable, srows_enable, mcols_enable, ark_enable, round_num};
    n_cmp++;
    if (v !== 11'b0) begin n_bad++; $display("FAIL reset_mid_async outputs=%b want 0", v); end
    nen = enq_stage.size();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    force_mask = 4'b0100; force_req++;
    repeat (20) @(negedge clk);
    #1;
    n_cmp++;
    if (enq_stage.size() != nen || done_q.size() != d) begin
      n_bad++; $display("FAIL reset_mid_quiet new enables=%0d dones=%0d want 0 0", enq_stage.size() - nen, done_q.size() - d);
    end
    n_cmp++;
    if (busy !== 1'b0 || round_num !== 4'd0) begin n_bad++; $display("FAIL reset_mid_idle busy=%b round=%0d want 0 0", busy, round_num); end
  endtask

`ifdef AES_ROUND_CTRL_WATCHDOG_EN
  task automatic test_watchdog();
    int b, d, ce;
    lat_mode = 1; stray_en = 1'b0; no_resp = 4'b0001;
    b = enq_stage.size(); d = done_q.size(); ce = -1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (error === 1'b1) begin ce = cyc; break; end
    end
    n_cmp++;
    if (enq_stage.size() - b != 2 || ce != enq_cyc[b + 1] + 255) begin
      n_bad++; $display("FAIL watchdog_time enables=%0d error_cyc=%0d want 2 sb+255", enq_stage.size() - b, ce);
    end
    n_cmp++;
    if (busy !== 1'b0 || {sbytes_enable, srows_enable, mcols_enable, ark_enable} !== 4'b0) begin
      n_bad++; $display("FAIL watchdog_error_outputs busy=%b en=%b want 0 0", busy, {sbytes_enable, srows_enable, mcols_enable, ark_enable});
    end
    no_resp = 4'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (error !== 1'b0 || ark_enable !== 1'b1 || round_num !== 4'd0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL watchdog_restart error=%b ark_en=%b round=%0d busy=%b want 0 1 0 1", error, ark_enable, round_num, busy);
    end
    for (int k = 0; k < 300 && done_q.size() == d; k++) @(posedge clk);
    n_cmp++;
    if (done_q.size() != d + 1) begin n_bad++; $display("FAIL watchdog_done count=%0d want 1", done_q.size() - d); end
  endtask
`else
  task automatic test_stall();
    int b, d;
    lat_mode = 1; stray_en = 1'b0; no_resp = 4'b0001;
    b = enq_stage.size(); d = done_q.size();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (300) @(negedge clk);
    n_cmp++;
    if (enq_stage.size() - b != 2 || done_q.size() != d || busy !== 1'b1 || error !== 1'b0 || round_num !== 4'd1) begin
      n_bad++; $display("FAIL stall_hold enables=%0d dones=%0d busy=%b error=%b round=%0d want 2 0 1 0 1",
                        enq_stage.size() - b, done_q.size() - d, busy, error, round_num);
    end
    no_resp = 4'b0; force_mask = 4'b0001; force_req++;
    for (int k = 0; k < 300 && done_q.size() == d; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    n_cmp++;
    if (done_q.size() != d + 1 || enq_stage.size() - b != 40) begin
      n_bad++; $display("FAIL stall_resume dones=%0d enables=%0d want 1 40", done_q.size() - d, enq_stage.size() - b);
    end
  endtask
`endif

  task automatic test_onehot();
    n_cmp++;
    if (multi_en != 0) begin n_bad++; $display("FAIL onehot_enables cycles_with_multiple=%0d want 0", multi_en); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_ROUND_CTRL_WATCHDOG_EN
    test_watchdog();
`else
    test_stall();
`endif
    test_onehot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the AES-128 encryption datapath. It drives the per-stage enable/finished handshakes in order: SubBytes, ShiftRows, MixColumns and AddRoundKey. It tracks the current round number and reports completion of a full block. It sits directly upstream of the SubBytes stage, producing `sbytes_enable` and consuming `sbytes_finished`, and issues the equivalent handshakes to the other three stages.

## Interface

- NUM_ROUNDS, 10, total AES rounds after initial key addition (AES-128)
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting on one stage before error (used only with watchdog)
- clk  in  1  clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- start  in  1  request to encrypt one block; sampled only in IDLE
- busy  out  1  high in every state except IDLE and ERROR
- done  out  1  one-cycle pulse: block complete
- error  out  1  stage timeout flag (watchdog only)
- round_num  out  4  current round, 0..NUM_ROUNDS
- sbytes_enable / srows_enable / mcols_enable / ark_enable  out  1 each  one-cycle stage start pulses
- sbytes_finished / srows_finished / mcols_finished / ark_finished  in  1 each  stage completion

## Operation

- States: IDLE, W_ARK0, W_SB, W_SR, W_MC, W_ARK, DONE, ERROR.
- IDLE, start=1 → W_ARK0; round_num=0.
- W_ARK0, ark_finished → W_SB; round_num=1.
- W_SB, sbytes_finished → W_SR.
- W_SR, srows_finished → W_MC if round_num<NUM_ROUNDS, else W_ARK (MixColumns skipped in the final round).
- W_MC, mcols_finished → W_ARK.
- W_ARK, ark_finished → DONE if round_num==NUM_ROUNDS; otherwise W_SB with round_num+1.
- DONE → IDLE unconditionally.
- Each stage enable is registered. It is high for exactly the first cycle spent in that stage's W_ state and low otherwise. Only one enable is high in any cycle.
- A stage's finished input is honoured only in that stage's W_ state, including the cycle its enable is high, so zero-latency stages are legal. A finished pulse in any other state, or from another stage, is ignored.
- start while busy is ignored. start in DONE is ignored; a new start is needed in IDLE.
- round_num is 4-bit unsigned. It holds its value in DONE and is cleared to 0 on entry to IDLE.
- Reset values: state IDLE, all enables 0, busy 0, done 0, error 0, round_num 0. Reset mid-block aborts immediately with no done pulse. A stage finished arriving after reset is ignored.

## Timing

- start sampled at edge E0. ark_enable is high in the cycle after E0.
- Enable-to-next-enable spacing is 1 cycle plus the stage latency. For a stage whose finished is high the cycle after its enable, each stage costs 2 cycles.
- Per block there are 1 + 4·(NUM_ROUNDS−1) + 3 = 40 stage operations. With 1-cycle stages, DONE is entered at E80 and done is high in the cycle after E80.
- busy rises in the cycle after E0 and falls in the cycle after done.
- done is high for exactly one cycle per completed block.

## Configuration

- Macro: AES_ROUND_CTRL_WATCHDOG_EN.
- Defined:
  - A wait counter is cleared on every W_ state entry and increments each cycle in W_ states.
  - Reaching TIMEOUT_CYCLES without the expected finished → ERROR.
  - In ERROR: error=1, busy=0, all enables 0. ERROR exits to W_ARK0 on start (error clears that edge); reset also clears it.
- Undefined: no counter, ERROR unreachable, error tied 0, and a stage may stall indefinitely.

## Structure

- Shared package aes_pkg: state enum type, AES_NUM_ROUNDS=10, round-number width constant.
- Sub-module aes_watchdog (8-bit counter, clear/enable, timeout output), instantiated only under AES_ROUND_CTRL_WATCHDOG_EN.

## Test plan

- Reset held, then released with start=0 → all outputs 0, state IDLE indefinitely.
- start pulse, all stages answer finished 1 cycle after enable → exactly 40 enables in the order ARK, (SB,SR,MC,ARK)×9, SB,SR,ARK. mcols_enable count is 9. done is high at cycle 81 after start and round_num=10 at done.
- Stage latencies randomised 0–5 cycles, with stray finished pulses on idle stages → same enable order, no spurious transitions, exactly one done.
- start asserted repeatedly while busy → ignored, a single done. start in the cycle after done (IDLE) → a second block runs correctly.
- n_rst asserted while in W_MC of round 5 → outputs reset immediately, no done. A late mcols_finished is ignored.
- With watchdog, sbytes_finished never returned → ERROR after 255 wait cycles with error=1. A following start clears error and restarts at W_ARK0.
